pixel_unpacker: RTL and testbench

Receive-side counterpart of the video `packer`. The block is an AXI-Stream slave that accepts the 32-bit packed RGB888 video stream (tuser marks the start of frame, tlast marks the end of line), unpacks 3 words into 4 pixels, and presents one pixel per handshake on a valid/ready output. It checks frame and line framing and resynchronises on errors. It sits at the input of loopback and capture paths, where the ray-marcher output is checked or re-consumed on-chip.

---
 rtl/pixel_unpacker_pkg.sv | 23 ++
 rtl/byte_fifo_unpack.sv | 51 +++++
 rtl/pixel_unpacker.sv | 143 ++++++++++++++
 tb/tb_pixel_unpacker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_unpacker_pkg.sv
// Shared packing definitions for the 32-bit packed RGB888 video stream.
// Used by both the packer and the unpacker so the byte layout is defined once.
package pixel_unpacker_pkg;

    localparam int unsigned SCREEN_WIDTH_DEF  = 640;
    localparam int unsigned SCREEN_HEIGHT_DEF = 480;
    localparam int unsigned COLOR_WIDTH_DEF   = 8;

    localparam int unsigned BYTES_PER_PIXEL = 3;
    localparam int unsigned BYTES_PER_WORD  = 4;

    typedef enum logic [0:0] {
        StSeekSof,
        StRun
    } unpack_state_e;

    function automatic int unsigned words_per_line(input int unsigned width);
        return width * BYTES_PER_PIXEL / BYTES_PER_WORD;
    endfunction

    localparam int unsigned WPL = words_per_line(SCREEN_WIDTH_DEF);

endpackage

// File: rtl/byte_fifo_unpack.sv
// 7-byte shift buffer: words are appended above the held bytes, pixels leave from the bottom.
// Flush clears the buffer before any push in the same cycle, so flush+push loads a fresh word.
module byte_fifo_unpack
    import pixel_unpacker_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [31:0] data_i,
    input  logic        pop_i,
    output logic [23:0] head_o,
    output logic [2:0]  cnt_o,
    output logic [2:0]  cnt_next_o
);

    logic [55:0] data_q, data_d;
    logic [2:0]  cnt_q, cnt_d;

    // Bytes above cnt are kept zero, so a push can simply OR the word into place.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (pop_i) begin
            data_d = {24'd0, data_q[55:24]};
            cnt_d  = cnt_q - 3'(BYTES_PER_PIXEL);
        end
        if (push_i) begin
            data_d = data_d | ({24'd0, data_i} << {cnt_d, 3'b000});
            cnt_d  = cnt_d + 3'(BYTES_PER_WORD);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o     = data_q[23:0];
    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/pixel_unpacker.sv
// AXI-Stream slave that unpacks 3 packed RGB888 words into 4 pixels, one pixel per handshake,
// checking frame/line framing and resynchronising on tuser/tlast errors.
module pixel_unpacker
    import pixel_unpacker_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int unsigned COLOR_WIDTH   = COLOR_WIDTH_DEF
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [31:0]            in_stream_tdata,
    input  logic [3:0]             in_stream_tkeep,
    input  logic                   in_stream_tuser,
    input  logic                   in_stream_tlast,
    input  logic                   in_stream_tvalid,
    output logic                   in_stream_tready,
    output logic [COLOR_WIDTH-1:0] r,
    output logic [COLOR_WIDTH-1:0] g,
    output logic [COLOR_WIDTH-1:0] b,
    output logic                   sof,
    output logic                   eol,
    output logic                   valid,
    input  logic                   ready,
    output logic [15:0]            frame_count,
    output logic                   sof_err,
    output logic                   eol_err
);

    localparam int unsigned Wpl      = words_per_line(SCREEN_WIDTH);
    localparam logic [15:0] LastWord = 16'(Wpl - 1);
    localparam logic [15:0] LastPx   = 16'(SCREEN_WIDTH - 1);
    localparam logic [15:0] LastLine = 16'(SCREEN_HEIGHT - 1);

    unpack_state_e state_q, state_d;
    logic          tready_q;
    logic [15:0]   wx_q, wy_q, px_q, py_q, frame_count_q;
    logic          sof_err_q, eol_err_q;

    logic [23:0]   head;
    logic [2:0]    cnt, cnt_next;
    logic          run, acc, emit, valid_int, at_origin;
    logic          resync, sof_bad, early_eol, missing_eol, normal_push;
    logic          unused_tkeep;

    function automatic logic [15:0] next_line(input logic [15:0] y);
        return (y == LastLine) ? 16'd0 : y + 16'd1;
    endfunction

    assign unused_tkeep = &in_stream_tkeep;

    assign run       = (state_q == StRun);
    assign acc       = in_stream_tvalid && tready_q;
    assign valid_int = run && (cnt >= 3'd3);
    assign emit      = valid_int && ready;
    assign at_origin = (wx_q == 16'd0) && (wy_q == 16'd0);

    // resync covers both the first capture in StSeekSof and a misplaced tuser in StRun.
    assign resync      = acc && in_stream_tuser && (!run || !at_origin);
    assign sof_bad     = resync && run;
    assign early_eol   = acc && run && !sof_bad && in_stream_tlast && (wx_q != LastWord);
    assign missing_eol = acc && run && !sof_bad && !in_stream_tlast && (wx_q == LastWord);
    assign normal_push = acc && run && !sof_bad && !early_eol;

    assign state_d = resync ? StRun : state_q;

    byte_fifo_unpack u_fifo (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .flush_i    (resync || early_eol),
        .push_i     (resync || normal_push),
        .data_i     (in_stream_tdata),
        .pop_i      (emit),
        .head_o     (head),
        .cnt_o      (cnt),
        .cnt_next_o (cnt_next)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= StSeekSof;
            tready_q      <= 1'b0;
            wx_q          <= '0;
            wy_q          <= '0;
            px_q          <= '0;
            py_q          <= '0;
            frame_count_q <= '0;
            sof_err_q     <= 1'b0;
            eol_err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Registered so tready never sees ready or tvalid combinationally.
            tready_q  <= (state_d == StSeekSof) || (cnt_next <= 3'd3);
            sof_err_q <= sof_bad;
            eol_err_q <= early_eol || missing_eol;

            if (resync) begin
                wx_q <= 16'd1;
                wy_q <= '0;
            end else if (early_eol) begin
                wx_q <= '0;
                wy_q <= next_line(wy_q);
            end else if (normal_push) begin
                if (wx_q == LastWord) begin
                    wx_q <= '0;
                    wy_q <= next_line(wy_q);
                end else begin
                    wx_q <= wx_q + 16'd1;
                end
            end

            if (resync) begin
                px_q <= '0;
                py_q <= '0;
            end else if (early_eol) begin
                px_q <= '0;
                py_q <= next_line(py_q);
            end else if (emit) begin
                if (px_q == LastPx) begin
                    px_q <= '0;
                    py_q <= next_line(py_q);
                    if (py_q == LastLine) begin
                        frame_count_q <= frame_count_q + 16'd1;
                    end
                end else begin
                    px_q <= px_q + 16'd1;
                end
            end
        end
    end

    assign in_stream_tready = tready_q;
    assign valid            = valid_int;
    assign b                = head[0 +: COLOR_WIDTH];
    assign g                = head[COLOR_WIDTH +: COLOR_WIDTH];
    assign r                = head[2*COLOR_WIDTH +: COLOR_WIDTH];
    assign sof              = valid_int && (px_q == 16'd0) && (py_q == 16'd0);
    assign eol              = valid_int && (px_q == LastPx);
    assign frame_count      = frame_count_q;
    assign sof_err          = sof_err_q;
    assign eol_err          = eol_err_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker on a small 8x4 screen: clean frames, garbage before SOF,
// random stalls, misplaced tuser, early tlast and missing tlast.
module tb_pixel_unpacker;

    localparam int unsigned W   = 8;
    localparam int unsigned H   = 4;
    localparam int unsigned WPL = W * 3 / 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] in_stream_tdata = '0;
    logic [3:0]  in_stream_tkeep = 4'hF;
    logic        in_stream_tuser = 1'b0;
    logic        in_stream_tlast = 1'b0;
    logic        in_stream_tvalid = 1'b0;
    logic        in_stream_tready;
    logic [7:0]  r, g, b;
    logic        sof, eol, valid;
    logic        ready = 1'b0;
    logic [15:0] frame_count;
    logic        sof_err, eol_err;

    always #5 aclk = ~aclk;

    pixel_unpacker #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .COLOR_WIDTH   (8)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .in_stream_tdata  (in_stream_tdata),
        .in_stream_tkeep  (in_stream_tkeep),
        .in_stream_tuser  (in_stream_tuser),
        .in_stream_tlast  (in_stream_tlast),
        .in_stream_tvalid (in_stream_tvalid),
        .in_stream_tready (in_stream_tready),
        .r                (r),
        .g                (g),
        .b                (b),
        .sof              (sof),
        .eol              (eol),
        .valid            (valid),
        .ready            (ready),
        .frame_count      (frame_count),
        .sof_err          (sof_err),
        .eol_err          (eol_err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
        logic        se;
        logic        ee;
    } word_t;

    word_t       wq[$];
    logic [25:0] eq[$];

    int          n_checks = 0;
    int          n_err = 0;
    logic        exp_se = 1'b0, exp_ee = 1'b0;
    logic        stall_pend = 1'b0;
    logic [25:0] held = '0;
    logic        tv_hold = 1'b0;
    logic        track = 1'b0;
    int          mcnt = 0;
    int unsigned rdy_pct = 100;
    int unsigned gap_pct = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int f, input int y, input int x);
        logic [7:0] rr;
        rr = 8'(f * 37 + y * 8 + x);
        return {rr, rr ^ 8'hA5, 8'(rr + 8'h3C)};
    endfunction

    // Byte n of a line: pixel n/3, in b, g, r order.
    function automatic logic [7:0] pbyte(input int f, input int y, input int n);
        logic [23:0] p;
        p = pix(f, y, n / 3);
        case (n % 3)
            0:       return p[7:0];
            1:       return p[15:8];
            default: return p[23:16];
        endcase
    endfunction

    task automatic push_words(input int f, input int y, input int k0, input int k1,
                              input logic user, input logic last, input logic se, input logic ee);
        word_t w;
        for (int k = k0; k <= k1; k++) begin
            w.data = {pbyte(f, y, 4*k+3), pbyte(f, y, 4*k+2), pbyte(f, y, 4*k+1), pbyte(f, y, 4*k)};
            w.user = user && (k == k0);
            w.last = last && (k == k1);
            w.se   = se && (k == k0);
            w.ee   = ee && (k == k1);
            wq.push_back(w);
        end
    endtask

    task automatic push_exp(input int f, input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            eq.push_back({pix(f, y, x), (x == 0 && y == 0), (x == int'(W) - 1)});
        end
    endtask

    task automatic push_frame(input int f);
        for (int y = 0; y < int'(H); y++) begin
            push_words(f, y, 0, int'(WPL) - 1, (y == 0), 1'b1, 1'b0, 1'b0);
            push_exp(f, y, 0, int'(W) - 1);
        end
    endtask

    task automatic drive_inputs();
        ready = ($urandom_range(99) < rdy_pct);
        if (!tv_hold) begin
            in_stream_tvalid = (wq.size() > 0) && ($urandom_range(99) >= gap_pct);
        end
        if (in_stream_tvalid) begin
            in_stream_tdata = wq[0].data;
            in_stream_tuser = wq[0].user;
            in_stream_tlast = wq[0].last;
        end else begin
            in_stream_tuser = 1'b0;
            in_stream_tlast = 1'b0;
        end
    endtask

    task automatic cycle();
        logic        acc, emit;
        logic [25:0] obs, e;
        @(negedge aclk);
        obs = {r, g, b, sof, eol};
        check("err_pulses", {sof_err, eol_err}, {exp_se, exp_ee});
        if (stall_pend) check("stall_hold", {valid, obs}, {1'b1, held});
        if (track) begin
            check("tready_vs_cnt", in_stream_tready, (mcnt <= 3));
            check("valid_vs_cnt", valid, (mcnt >= 3));
        end
        acc  = in_stream_tvalid && in_stream_tready;
        emit = valid && ready;
        if (emit) begin
            check("pixel_pending", (eq.size() != 0), 1'b1);
            if (eq.size() != 0) begin
                e = eq.pop_front();
                check("pixel", obs, e);
            end
        end
        exp_se = acc && wq[0].se;
        exp_ee = acc && wq[0].ee;
        if (track) mcnt = mcnt + 4 * int'(acc) - 3 * int'(emit);
        if (acc) void'(wq.pop_front());
        stall_pend = valid && !ready;
        held       = obs;
        tv_hold    = in_stream_tvalid && !acc;
        @(posedge aclk);
        #1;
        drive_inputs();
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((wq.size() > 0 || eq.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_in_budget", (n < budget), 1'b1);
        wq.delete();
        eq.delete();
        repeat (4) cycle();
    endtask

    task automatic do_reset();
        aresetn          = 1'b0;
        in_stream_tvalid = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tlast  = 1'b0;
        ready            = 1'b0;
        wq.delete();
        eq.delete();
        exp_se     = 1'b0;
        exp_ee     = 1'b0;
        stall_pend = 1'b0;
        tv_hold    = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_tready", in_stream_tready, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_sof_eol", {sof, eol}, 2'b00);
        check("rst_rgb", {r, g, b}, 24'd0);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_errs", {sof_err, eol_err}, 2'b00);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("tready_after_reset", in_stream_tready, 1'b1);
        drive_inputs();
    endtask

    initial begin
        word_t w;

        // Two clean frames at full output rate.
        rdy_pct = 100;
        gap_pct = 0;
        do_reset();
        push_frame(1);
        push_frame(2);
        run(1000);
        check("fc_two_frames", frame_count, 16'd2);

        // Reset in mid-frame, then garbage words before the first tuser.
        push_frame(3);
        repeat (12) cycle();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w.data = 32'hC0DE_0000 + 32'(i);
            w.user = 1'b0;
            w.last = (i == 2);
            w.se   = 1'b0;
            w.ee   = 1'b0;
            wq.push_back(w);
        end
        push_frame(4);
        run(1000);
        check("fc_after_garbage", frame_count, 16'd1);

        // Random output stalls and input gaps, with byte-count tracking.
        rdy_pct = 50;
        gap_pct = 30;
        mcnt    = 0;
        track   = 1'b1;
        push_frame(5);
        push_frame(6);
        run(3000);
        track = 1'b0;
        check("fc_random", frame_count, 16'd3);

        // Partial frame cut at line 3 word 4 by a new tuser.
        rdy_pct = 100;
        gap_pct = 0;
        for (int y = 0; y < 3; y++) begin
            push_words(7, y, 0, int'(WPL) - 1, (y == 0), 1'b1, 1'b0, 1'b0);
            push_exp(7, y, 0, int'(W) - 1);
        end
        push_words(7, 3, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(7, 3, 0, 4);
        run(1000);
        check("fc_partial_frame", frame_count, 16'd3);
        for (int y = 0; y < int'(H); y++) begin
            push_words(8, y, 0, int'(WPL) - 1, (y == 0), 1'b1, (y == 0), 1'b0);
            push_exp(8, y, 0, int'(W) - 1);
        end
        run(1000);
        check("fc_after_sof_err", frame_count, 16'd4);

        // Early tlast on line 1 word 4: that word is dropped, output jumps to line 2.
        push_words(9, 0, 0, int'(WPL) - 1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(9, 0, 0, int'(W) - 1);
        push_words(9, 1, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        push_words(9, 1, 4, 4, 1'b0, 1'b1, 1'b0, 1'b1);
        push_exp(9, 1, 0, 4);
        for (int y = 2; y < int'(H); y++) begin
            push_words(9, y, 0, int'(WPL) - 1, 1'b0, 1'b1, 1'b0, 1'b0);
            push_exp(9, y, 0, int'(W) - 1);
        end
        run(1000);
        check("fc_after_early_eol", frame_count, 16'd5);

        // Missing tlast on line 2: data and line alignment are unaffected.
        for (int y = 0; y < int'(H); y++) begin
            push_words(10, y, 0, int'(WPL) - 1, (y == 0), (y != 2), 1'b0, (y == 2));
            push_exp(10, y, 0, int'(W) - 1);
        end
        run(1000);
        check("fc_after_missing_eol", frame_count, 16'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
